// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus.
// At most one requester drives the bus at a time, and the bus is always
// released for a turnaround gap between owners, so two drivers never fight.
// A grant lasts as long as its owner keeps requesting, up to MAX_HOLD cycles.
// All outputs are registered.
module tristate_bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MAX_HOLD   = 4,
    parameter int TURNAROUND = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           oe,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       bus_idle
);

    localparam int OWN_W  = $clog2(N_REQ);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);
    localparam logic [OWN_W-1:0]  OWN_TOP   = OWN_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]  ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t            state_r;
    logic [N_REQ-1:0]  oe_r;
    logic [OWN_W-1:0]  owner_r;
    logic              bus_idle_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [TURN_W-1:0] turn_cnt_r;
    logic [OWN_W-1:0]  last_owner_r;
    logic [OWN_W-1:0]  winner_s;

    // First asserted request scanning upward from last+1, wrapping; the
    // previous owner is considered last, so it only wins when it is alone.
    function automatic logic [OWN_W-1:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [OWN_W-1:0] last
    );
        logic [OWN_W-1:0] pick;
        logic [OWN_W-1:0] idx;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = OWN_W'((int'(last) + i) % N_REQ);
            if (!found && r[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    // Round-robin winner for the next grant decision.
    always_comb begin
        winner_s = rr_pick(req, last_owner_r);
    end

    // Arbitration FSM; outputs are updated together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            oe_r         <= '0;
            owner_r      <= '0;
            bus_idle_r   <= 1'b1;
            hold_cnt_r   <= '0;
            turn_cnt_r   <= '0;
            last_owner_r <= OWN_TOP;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        state_r    <= GRANT;
                        oe_r       <= ONE_HOT0 << winner_s;
                        owner_r    <= winner_s;
                        bus_idle_r <= 1'b0;
                        hold_cnt_r <= '0;
                    end else begin
                        oe_r       <= '0;
                        owner_r    <= '0;
                        bus_idle_r <= 1'b1;
                    end
                end
                GRANT: begin
                    // Only the owner's own request matters while it holds the bus.
                    if (!req[owner_r] || (hold_cnt_r == HOLD_LAST)) begin
                        state_r      <= TURN;
                        oe_r         <= '0;
                        owner_r      <= '0;
                        bus_idle_r   <= 1'b1;
                        last_owner_r <= owner_r;
                        hold_cnt_r   <= '0;
                        turn_cnt_r   <= '0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                TURN: begin
                    if (turn_cnt_r == TURN_LAST) begin
                        turn_cnt_r <= '0;
                        if (|req) begin
                            state_r    <= GRANT;
                            oe_r       <= ONE_HOT0 << winner_s;
                            owner_r    <= winner_s;
                            bus_idle_r <= 1'b0;
                            hold_cnt_r <= '0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        turn_cnt_r <= turn_cnt_r + TURN_W'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    oe_r       <= '0;
                    owner_r    <= '0;
                    bus_idle_r <= 1'b1;
                    hold_cnt_r <= '0;
                    turn_cnt_r <= '0;
                end
            endcase
        end
    end

    assign oe       = oe_r;
    assign owner    = owner_r;
    assign bus_idle = bus_idle_r;

endmodule

// File: doc/tristate_bus_arbiter.md
TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one tristate bus (2..8).
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive bus cycles per grant (>=1).
REQ-003 Parameter TURNAROUND, default 1, all-released cycles between owners (>=1).
REQ-004 Port clk input 1: single clock; all state updates on rising edge.
REQ-005 Port rst input 1: reset, synchronous, active-high.
REQ-006 Port req input N_REQ: per-requester bus request, level-sensitive.
REQ-007 Port oe output N_REQ: one-hot or zero enable to each requester's tristate driver (enable=1 drives data_out, 0 gives Z).
REQ-008 Port owner output clog2(N_REQ): index of current owner, valid only when oe nonzero, else 0.
REQ-009 Port bus_idle output 1: high when oe is all zero (bus floating Z).

Function
REQ-010 All outputs SHALL be registered; oe SHALL never have more than one bit set, in any cycle.
REQ-011 FSM states SHALL be IDLE, GRANT, TURN.
REQ-012 IDLE: oe=0; if req nonzero at an edge, SHALL go to GRANT with winner's oe bit high from the next cycle (1-cycle latency).
REQ-013 Winner selection SHALL be round-robin: first asserted req scanning upward from last_owner+1, wrapping from N_REQ-1 to 0.
REQ-014 GRANT: oe[owner]=1; hold counter SHALL start at 0 on entry and increment each cycle in GRANT.
REQ-015 GRANT exit to TURN at the edge where req[owner] is sampled low or hold counter equals MAX_HOLD-1, whichever first; last_owner SHALL be updated to owner on exit.
REQ-016 Owner deasserting req SHALL cause oe release at the next edge; oe is high for every cycle req[owner] was sampled high, up to MAX_HOLD.
REQ-017 TURN: oe=0 for exactly TURNAROUND cycles; TURN counter SHALL start at 0 on entry.
REQ-018 At end of TURN: if req nonzero, go to GRANT with round-robin winner (may equal last_owner if it is the sole requester); else go to IDLE.
REQ-019 New requests arriving during GRANT or TURN SHALL NOT preempt the owner or shorten TURN.
REQ-020 Requests from non-owners SHALL be ignored while in GRANT; only req[owner] affects GRANT.
REQ-021 Simultaneous requests in IDLE or at TURN end SHALL resolve by REQ-013 only; no fixed priority beyond it.
REQ-022 bus_idle SHALL equal NOR of oe in every cycle.

Reset
REQ-023 rst high at an edge SHALL set state IDLE, oe=0, owner=0, bus_idle=1, hold and TURN counters=0, last_owner=N_REQ-1 (requester 0 first).
REQ-024 rst SHALL override all other inputs, including mid-GRANT and mid-TURN; bus SHALL float Z from the cycle after the reset edge.
REQ-025 First grant after reset release SHALL follow REQ-012 with no extra delay.

Verification (N_REQ=4, MAX_HOLD=4, TURNAROUND=1)
REQ-026 Reset: rst=1 for 2 cycles with req=4'b1111 -> oe=4'b0000, owner=0, bus_idle=1 throughout.
REQ-027 Single short request: req=4'b0001 for 2 edges, then 0 -> oe=4'b0001 for 2 cycles starting 1 cycle after req rise, then 1 cycle oe=0 (TURN), then IDLE.
REQ-028 Full contention: req=4'b1111 held -> oe sequence 0001x4, 0000x1, 0010x4, 0000x1, 0100x4, 0000x1, 1000x4, 0000x1, 0001x4; owner tracks 0,1,2,3,0.
REQ-029 Sole hog: req=4'b0010 held -> oe=0010 for 4 cycles, 0000 for 1 cycle, 0010 again, repeating; owner=1.
REQ-030 Reset mid-grant: during owner=2 with 2 hold cycles used, rst=1 for 1 cycle -> oe=0 next cycle; release with req=4'b1001 -> oe=4'b0001 first.
REQ-031 Handover safety: req[3] rises during grant to 0, req[0] drops -> oe never multi-hot, exactly 1 cycle of oe=0 between 0001 and 1000; one-hot and bus_idle checks asserted every cycle for all scenarios.
